load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage of the RISC-V datapath, directly downstream of the ALU. It uses the ALU result as the effective address and performs byte, halfword and word loads and stores over a valid/ack memory bus. It stalls the core while an access is in flight and returns sign- or zero-extended load data to the writeback mux. Misaligned, illegal and timed-out accesses are reported as faults instead of being issued or completed silently.

## Interface
- TIMEOUT_CYCLES, 255, REQ cycles without BusAck before the access is abandoned; 0 disables the timeout.

- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- MemRead  input  1  load request; held stable by the core while Stall=1
- MemWrite  input  1  store request; held stable while Stall=1
- Funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu (bu/hu loads only)
- ALUResult  input  32  effective byte address
- WriteData  input  32  store data (rs2)
- ReadData  output  32  extended load result, registered
- Stall  output  1  core must hold PC and inputs this cycle
- MemFault  output  1  one-cycle fault pulse
- BusReq  output  1  bus request, registered
- BusWe  output  1  1 = write, registered
- BusAddr  output  32  word-aligned address {ALUResult[31:2],2'b00}, registered
- BusWData  output  32  lane-replicated store data, registered
- BusBe  output  4  byte enables, registered
- BusAck  input  1  access complete; BusRData valid same cycle
- BusRData  input  32  read data word

## Operation
- FSM states: IDLE, REQ, DONE.
- Request = MemRead|MemWrite. Illegal = both set; or a store with Funct3 ≥ 011; or a load with Funct3 ∈ {011,110,111}. Misaligned = h/hu with ALUResult[0]=1, or w with ALUResult[1:0]≠0.
- IDLE, request, legal and aligned: latch bus outputs, BusReq←1, go to REQ. Stall=1.
- IDLE, request, illegal or misaligned: no bus access, stay in IDLE. MemFault=1 (combinational, same cycle). Stall=0. ReadData←0 at the edge.
- REQ: hold all bus outputs stable and count cycles.
  - On BusAck=1: BusReq←0; for loads, ReadData←extended data; go to DONE.
  - If count reaches TIMEOUT_CYCLES (nonzero) without ack: BusReq←0, ReadData←0, flag timeout, go to DONE.
  - Stall=1 throughout REQ.
- DONE: Stall=0 (the instruction retires this cycle). MemFault=1 if the access timed out. Request inputs are ignored. Go to IDLE unconditionally.
- Byte enables: b → 0001<<addr[1:0]; h → addr[1] ? 1100 : 0011; w → 1111. Loads drive the same BusBe with BusWe=0.
- Store data: sb {4{WriteData[7:0]}}, sh {2{WriteData[15:0]}}, sw WriteData.
- Load extract: shift BusRData right by 8·addr[1:0]. lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw passes the word through.
- ReadData holds its value until the next completed load or fault. Stores do not modify it.
- BusAck outside REQ is ignored.

## Timing
- Reset values: state IDLE; BusReq, BusWe, BusBe, BusAddr, BusWData, ReadData all 0; timeout counter 0; Stall=0; MemFault=0.
- Reset asserted mid-access: the access is abandoned at that edge, BusReq is 0 the next cycle, and a late BusAck is ignored.
- Minimum access takes 3 cycles: IDLE (detect), REQ (ack in the first REQ cycle), DONE.
- Latency = 2 + number of REQ cycles. Stall is high for all cycles before DONE.
- BusReq rises one cycle after request detection. It stays high through the cycle where BusAck is sampled and is low in DONE.
- Timeout: with no ack, exactly TIMEOUT_CYCLES cycles are spent in REQ, then DONE with MemFault=1.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter clears on REQ entry.
- Back-to-back accesses: a new request is detected in the IDLE cycle immediately after DONE.

## Test plan
- lw, ALUResult=0x100, ack in the first REQ cycle, BusRData=0xDEADBEEF:
  - BusAddr=0x100, BusBe=1111, BusWe=0.
  - Stall high for 2 cycles; ReadData=0xDEADBEEF in DONE.
- lb at 0x103 with BusRData=0x80FF0011 → ReadData=0xFFFFFF80. Same access with lbu → 0x00000080.
- sh at 0x202, WriteData=0x1234ABCD, ack after 3 REQ cycles → BusAddr=0x200, BusBe=1100, BusWData=0xABCDABCD, BusWe=1, total latency 5 cycles, ReadData unchanged.
- Misaligned and illegal requests:
  - lw at 0x101 → MemFault=1 and Stall=0 in the same cycle, BusReq never rises, ReadData=0.
  - MemRead=MemWrite=1 → MemFault=1.
- TIMEOUT_CYCLES=4, no ack → BusReq high exactly 4 cycles, then DONE with MemFault=1, ReadData=0, back to IDLE.
- reset asserted in the second REQ cycle → next cycle all outputs at reset values; BusAck=1 one cycle later produces no ReadData change and no Stall.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage of the RISC-V datapath.
//
// Takes the ALU result as the effective byte address and performs byte, halfword and word
// loads/stores over a valid/ack bus. The core is stalled while an access is in flight.
// Illegal, misaligned and timed-out accesses are reported with a one-cycle MemFault pulse.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   MemRead, MemWrite   load / store request (held stable by the core while Stall=1)
//   Funct3              access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   ALUResult           effective byte address
//   WriteData           store data (rs2)
//   ReadData            extended load result (registered)
//   Stall               core must hold PC and inputs this cycle
//   MemFault            one-cycle fault pulse
//   BusReq/BusWe/BusAddr/BusWData/BusBe   registered bus request outputs
//   BusAck, BusRData    bus completion and read data (valid in the same cycle)
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255  // 0 disables the timeout
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemFault,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusBe,
  input  logic        BusAck,
  input  logic [31:0] BusRData
);

  // At least one bit so a disabled timeout still yields a legal vector.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Counter value seen in the last permitted REQ cycle (counter is 0 in the first one).
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      funct3_q;

  logic        request;
  logic        illegal;
  logic        misaligned;
  logic        fault_now;
  logic        start;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Request decode
  always_comb begin
    request    = MemRead | MemWrite;
    illegal    = (MemRead & MemWrite) |
                 (MemWrite & (Funct3 >= 3'b011)) |
                 (MemRead & ((Funct3 == 3'b011) | (Funct3[2:1] == 2'b11)));
    misaligned = ((Funct3[1:0] == 2'b01) & ALUResult[0]) |
                 ((Funct3 == 3'b010) & (|ALUResult[1:0]));
    fault_now  = (state_q == StIdle) & request & (illegal | misaligned);
    start      = (state_q == StIdle) & request & ~(illegal | misaligned);
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteData;
    unique case (Funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << ALUResult[1:0];
        wdata_d = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_d    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteData[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = WriteData;
      end
    endcase
  end

  // Load extraction uses the size and offset latched at request time.
  always_comb begin
    shifted   = BusRData >> {addr_lo_q, 3'b000};
    load_data = shifted;
    unique case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'b0, shifted[7:0]};
      3'b101:  load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    Stall    = start | (state_q == StReq);
    MemFault = fault_now | ((state_q == StDone) & timeout_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      addr_lo_q <= 2'b00;
      funct3_q  <= 3'b000;
      ReadData  <= '0;
      BusReq    <= 1'b0;
      BusWe     <= 1'b0;
      BusAddr   <= '0;
      BusWData  <= '0;
      BusBe     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timeout_q <= 1'b0;
          if (start) begin
            BusReq    <= 1'b1;
            BusWe     <= MemWrite;
            BusAddr   <= {ALUResult[31:2], 2'b00};
            BusWData  <= wdata_d;
            BusBe     <= be_d;
            addr_lo_q <= ALUResult[1:0];
            funct3_q  <= Funct3;
            cnt_q     <= '0;
            state_q   <= StReq;
          end else if (fault_now) begin
            ReadData <= '0;
          end
        end
        StReq: begin
          // An ack in the last permitted cycle still completes the access.
          if (BusAck) begin
            BusReq <= 1'b0;
            if (!BusWe) begin
              ReadData <= load_data;
            end
            state_q <= StDone;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
            BusReq    <= 1'b0;
            ReadData  <= '0;
            timeout_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          timeout_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with TIMEOUT_CYCLES=4: directed cases followed by
// randomized accesses checked against a transaction-level reference model.
module tb_load_store_unit;

  localparam int unsigned Timeout = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, MemFault, BusReq, BusWe;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusBe;
  logic        BusAck;
  logic [31:0] BusRData;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_rd   = '0;

  load_store_unit #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Funct3   (Funct3),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Stall    (Stall),
    .MemFault (MemFault),
    .BusReq   (BusReq),
    .BusWe    (BusWe),
    .BusAddr  (BusAddr),
    .BusWData (BusWData),
    .BusBe    (BusBe),
    .BusAck   (BusAck),
    .BusRData (BusRData)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model helpers, phrased as sizes and arithmetic on the address
  function automatic int unsigned acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a);
    if (rd && wr) return 0;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    return (a % acc_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [31:0] v;
    v = word / (32'd1 << (8 * (a % 4)));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz = acc_size(f3);
    return ((32'd1 << sz) - 1) << (a % 4);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (acc_size(f3) == 1) return (d % 256) * 32'h0101_0101;
    if (acc_size(f3) == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  // One access. Entered just after a negedge; ack_k = REQ cycle carrying the ack
  // (0 or > Timeout means no ack).
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int unsigned ack_k, input logic [31:0] rdata);
    bit          legal = is_legal(rd, wr, f3, a);
    int unsigned req_cycles;
    bit          tmo;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = a; WriteData = wd;
    @(negedge clk);
    if (!legal) begin
      check_eq("fault_pulse", MemFault, 1);
      check_eq("fault_stall", Stall, 0);
      check_eq("fault_busreq", BusReq, 0);
      @(posedge clk); #1;
      MemRead = 0; MemWrite = 0;
      exp_rd = '0;
      @(negedge clk);
      check_eq("fault_rdata", ReadData, exp_rd);
      check_eq("fault_busreq2", BusReq, 0);
      check_eq("fault_clear", MemFault, 0);
      return;
    end
    check_eq("detect_stall", Stall, 1);
    check_eq("detect_fault", MemFault, 0);
    check_eq("detect_busreq", BusReq, 0);
    tmo        = (ack_k == 0) || (ack_k > Timeout);
    req_cycles = tmo ? Timeout : ack_k;
    for (int k = 1; k <= int'(req_cycles); k++) begin
      @(posedge clk); #1;
      BusAck   = !tmo && (k == int'(ack_k));
      BusRData = BusAck ? rdata : $urandom;
      @(negedge clk);
      check_eq("req_busreq", BusReq, 1);
      check_eq("req_stall", Stall, 1);
      check_eq("req_fault", MemFault, 0);
      check_eq("req_addr", BusAddr, a & 32'hFFFF_FFFC);
      check_eq("req_be", BusBe, model_be(f3, a));
      check_eq("req_we", BusWe, wr);
      if (wr) check_eq("req_wdata", BusWData, model_wdata(f3, wd));
    end
    @(posedge clk); #1;
    BusAck = 0;
    if (tmo) exp_rd = '0;
    else if (rd) exp_rd = model_load(f3, a, rdata);
    @(negedge clk);
    check_eq("done_stall", Stall, 0);
    check_eq("done_busreq", BusReq, 0);
    check_eq("done_fault", MemFault, tmo);
    check_eq("done_rdata", ReadData, exp_rd);
    MemRead = 0; MemWrite = 0;
  endtask

  initial begin
    reset = 1; MemRead = 0; MemWrite = 0; Funct3 = 0; ALUResult = 0; WriteData = 0;
    BusAck = 0; BusRData = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busreq", BusReq, 0);
    check_eq("rst_rdata", ReadData, 0);
    check_eq("rst_stall", Stall, 0);
    check_eq("rst_fault", MemFault, 0);
    check_eq("rst_be", BusBe, 0);
    reset = 0;

    // Directed cases
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD_BEEF);
    check_eq("lw_result", ReadData, 32'hDEAD_BEEF);
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0011);
    check_eq("lb_result", ReadData, 32'hFFFF_FF80);
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0011);
    check_eq("lbu_result", ReadData, 32'h0000_0080);
    do_access(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 3, 32'h0);
    check_eq("sh_keeps_rdata", ReadData, 32'h0000_0080);
    do_access(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0);
    do_access(1, 1, 3'b010, 32'h100, 32'h0, 1, 32'h0);
    do_access(1, 0, 3'b010, 32'h300, 32'h0, 0, 32'h0);
    do_access(1, 0, 3'b010, 32'h304, 32'h0, Timeout, 32'h1357_9BDF);

    // Reset in the second REQ cycle, then a late ack
    @(posedge clk); #1;
    MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; MemRead = 0;
    @(posedge clk); #1;
    reset = 0;
    exp_rd = '0;
    @(negedge clk);
    check_eq("midrst_busreq", BusReq, 0);
    check_eq("midrst_stall", Stall, 0);
    check_eq("midrst_rdata", ReadData, exp_rd);
    check_eq("midrst_addr", BusAddr, 0);
    check_eq("midrst_wdata", BusWData, 0);
    check_eq("midrst_be", BusBe, 0);
    check_eq("midrst_we", BusWe, 0);
    @(posedge clk); #1;
    BusAck = 1; BusRData = 32'hCAFE_F00D;
    @(negedge clk);
    check_eq("lateack_stall", Stall, 0);
    check_eq("lateack_busreq", BusReq, 0);
    @(posedge clk); #1;
    BusAck = 0;
    @(negedge clk);
    check_eq("lateack_rdata", ReadData, exp_rd);

    // Randomized accesses
    for (int i = 0; i < 120; i++) begin
      bit          rd, wr;
      int unsigned sel = $urandom_range(0, 9);
      rd = (sel < 5) || (sel == 9);
      wr = (sel >= 5);
      do_access(rd, wr, 3'($urandom_range(0, 7)), 32'($urandom),
                32'($urandom), $urandom_range(0, Timeout + 1), 32'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Guard against a hang; every access above is bounded by construction.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
